// File: rtl/uart_frame_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_frame_receiver_pkg                                   |
// | Purpose  : Shared constants and byte-FSM state encoding for the UART |
// |            frame transmitter/receiver pair.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_frame_receiver_pkg;

  // Frame header bytes, first and second on the wire
  localparam logic [7:0] HDR0 = 8'hBA;
  localparam logic [7:0] HDR1 = 8'hFD;

  // Frame geometry: 11 bytes, first byte in the top bits
  localparam int FRAME_BYTES = 11;
  localparam int FRAME_W     = 88;

  // Byte-level serial state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage : uart_frame_receiver_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_byte                                              |
// | Purpose  : 8N1 serial byte receiver with 2-flop input synchronizer.  |
// | Ports    : clk          - system clock (rising edge)                 |
// |            rst          - asynchronous active-high reset             |
// |            rx_i         - asynchronous serial line, idle high        |
// |            byte_o       - last byte received with a good stop bit    |
// |            byte_valid_o - 1-cycle pulse when byte_o updates          |
// |            err_o        - 1-cycle pulse when the stop bit is low     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_rx_byte
  import uart_frame_receiver_pkg::*;
#(
  parameter int clkfreq  = 100000000,
  parameter int baudrate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int c_BIT_LIM = clkfreq / baudrate;
  localparam int c_TMR_W   = (c_BIT_LIM > 1) ? $clog2(c_BIT_LIM) : 1;

  // Terminal counts: a full bit period and half a bit (to reach mid-bit)
  localparam logic [c_TMR_W-1:0] c_BIT_END  = c_TMR_W'(c_BIT_LIM - 1);
  localparam logic [c_TMR_W-1:0] c_HALF_END = c_TMR_W'((c_BIT_LIM / 2) - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               w_rx_s;
  uart_state_t        r_state;
  uart_state_t        w_state_next;
  logic [c_TMR_W-1:0] r_timer;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_shift;
  logic               w_timer_clr;
  logic               w_sample_bit;
  logic               w_stop_ok;
  logic               w_stop_bad;

  // Synchronizer flops reset to the idle line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_clr  = 1'b0;
    w_sample_bit = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = ST_START;
          w_timer_clr  = 1'b1;
        end
      end
      ST_START: begin
        // Mid start bit: a high line here means the falling edge was a glitch
        if (r_timer == c_HALF_END) begin
          w_timer_clr  = 1'b1;
          w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_timer == c_BIT_END) begin
          w_timer_clr  = 1'b1;
          w_sample_bit = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed
        if (r_timer == c_BIT_END) begin
          w_timer_clr  = 1'b1;
          w_state_next = ST_IDLE;
          w_stop_ok    = w_rx_s;
          w_stop_bad   = ~w_rx_s;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer      <= '0;
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'h00;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (w_timer_clr || (r_state == ST_IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (r_state == ST_START) begin
        r_bitcnt <= 3'd0;
      end else if (w_sample_bit) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_sample_bit) begin
        r_shift[r_bitcnt] <= w_rx_s;
      end

      byte_valid_o <= w_stop_ok;
      err_o        <= w_stop_bad;
      if (w_stop_ok) begin
        byte_o <= r_shift;
      end
    end
  end

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_frame_receiver                                       |
// | Purpose  : Receives 8N1 bytes and assembles 11-byte frames that      |
// |            start with the header BA FD.                              |
// | Ports    : clk           - system clock (rising edge)                |
// |            rst           - asynchronous active-high reset            |
// |            rx_i          - asynchronous serial line, idle high       |
// |            byte_o        - last correctly received byte              |
// |            byte_valid_o  - 1-cycle pulse when byte_o updates         |
// |            frame_o       - last complete frame, first byte in MSBs   |
// |            frame_valid_o - 1-cycle pulse when frame_o updates        |
// |            err_o         - 1-cycle pulse on a framing error          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_frame_receiver
  import uart_frame_receiver_pkg::*;
#(
  parameter int clkfreq  = 100000000,
  parameter int baudrate = 115200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_i,
  output logic [7:0]         byte_o,
  output logic               byte_valid_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_valid_o,
  output logic               err_o
);

  localparam logic [3:0] c_LAST_IDX = 4'(FRAME_BYTES - 1);

  logic [3:0]         r_idx;
  logic [FRAME_W-1:0] r_buf;
  logic [3:0]         w_idx_next;
  logic               w_accept;
  logic               w_frame_done;
  logic [6:0]         w_lsb;

  uart_rx_byte #(
    .clkfreq  (clkfreq),
    .baudrate (baudrate)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .err_o        (err_o)
  );

  // Byte k of the frame lives at bits [87-8k : 80-8k]
  assign w_lsb = 7'(FRAME_W - 8 - 8 * int'(r_idx));

  always_comb begin
    w_accept     = 1'b1;
    w_idx_next   = r_idx + 4'd1;
    w_frame_done = 1'b0;
    case (r_idx)
      4'd0: begin
        if (byte_o != HDR0) begin
          w_accept   = 1'b0;
          w_idx_next = 4'd0;
        end
      end
      4'd1: begin
        if (byte_o == HDR0) begin
          // A repeated first header byte may itself start the real frame;
          // byte 0 already holds HDR0, so just wait for HDR1 again.
          w_accept   = 1'b0;
          w_idx_next = 4'd1;
        end else if (byte_o != HDR1) begin
          w_accept   = 1'b0;
          w_idx_next = 4'd0;
        end
      end
      c_LAST_IDX: begin
        w_frame_done = 1'b1;
        w_idx_next   = 4'd0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx         <= 4'd0;
      r_buf         <= '0;
      frame_o       <= '0;
      frame_valid_o <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      if (err_o) begin
        r_idx <= 4'd0;
      end else if (byte_valid_o) begin
        if (w_accept) begin
          r_buf[w_lsb +: 8] <= byte_o;
        end
        r_idx <= w_idx_next;
        if (w_frame_done) begin
          // Last byte goes straight into the output so the frame appears
          // one cycle after its final byte_valid_o.
          frame_o       <= {r_buf[FRAME_W-1:8], byte_o};
          frame_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule : uart_frame_receiver
`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_frame_receiver                                    |
// | Purpose  : Scoreboard bench for uart_frame_receiver at 10 clocks/bit |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_frame_receiver;
  import uart_frame_receiver_pkg::*;

  localparam int BIT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic [87:0] frame_o;
  logic        frame_valid_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_bytes[$];
  logic [87:0] exp_frames[$];
  int          exp_errs = 0;
  logic [87:0] hold_frame = '0;
  logic [87:0] mon_exp;
  int          cyc = 0;
  int          last_bv_cyc = -100;
  logic        prev_bv = 1'b0;
  logic        prev_fv = 1'b0;
  logic        prev_err = 1'b0;

  uart_frame_receiver #(
    .clkfreq  (1000000),
    .baudrate (100000)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (rx_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (byte_valid_o) begin
        if (exp_bytes.size() == 0) begin
          check("unexpected_byte", 88'(byte_o), 88'hFFFF);
        end else begin
          mon_exp = 88'(exp_bytes.pop_front());
          check("byte", 88'(byte_o), mon_exp);
        end
        check("bv_err_exclusive", 88'(err_o), 88'd0);
        check("bv_single_cycle", 88'(prev_bv), 88'd0);
        last_bv_cyc = cyc;
      end
      if (err_o) begin
        check("err_expected", 88'(exp_errs > 0), 88'd1);
        if (exp_errs > 0) exp_errs--;
        check("err_single_cycle", 88'(prev_err), 88'd0);
      end
      if (frame_valid_o) begin
        if (exp_frames.size() == 0) begin
          check("unexpected_frame", frame_o, 88'hFFFF);
        end else begin
          mon_exp = exp_frames.pop_front();
          check("frame", frame_o, mon_exp);
          hold_frame = mon_exp;
        end
        check("frame_latency", 88'(cyc - last_bv_cyc), 88'd1);
        check("fv_single_cycle", 88'(prev_fv), 88'd0);
      end
    end
    prev_bv  = byte_valid_o;
    prev_fv  = frame_valid_o;
    prev_err = err_o;
  end

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx_i = v;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) exp_bytes.push_back(b);
    else         exp_errs++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic send_frame(input logic [87:0] f);
    exp_frames.push_back(f);
    for (int k = 0; k < 11; k++) send_byte(f[87 - 8*k -: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk);
    rx_i = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  // Watchdog: the run must never hang
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [87:0] f1, f2, f3, f4, f5;
  logic [7:0]  b7;

  initial begin
    f1 = 88'hBAFD_0001_0203_0405_0607_08;
    f2 = 88'hBAFD_1011_1213_1415_1617_18;
    f3 = 88'hBAFD_3031_3233_3435_3637_38;
    f4 = 88'hBAFD_4041_4243_4445_4647_48;
    f5 = 88'hBAFD_5051_5253_5455_5657_58;

    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte_o", 88'(byte_o), 88'h0);
    check("rst_frame_o", frame_o, 88'h0);
    check("rst_byte_valid", 88'(byte_valid_o), 88'h0);
    check("rst_frame_valid", 88'(frame_valid_o), 88'h0);
    check("rst_err", 88'(err_o), 88'h0);
    check("rst_state", 88'(u_dut.u_rx.r_state), 88'(ST_IDLE));
    rst = 1'b0;
    idle_bits(2);

    // Single byte
    send_byte(8'h55, 1'b1);
    idle_bits(2);
    check("single_byte_hold", 88'(byte_o), 88'h55);

    // Back-to-back frame
    send_frame(f1);
    idle_bits(2);
    check("frame1_hold", frame_o, f1);

    // Leading garbage 11 BA then the real frame BA FD + 9 data bytes
    exp_frames.push_back(f2);
    send_byte(8'h11, 1'b1);
    send_byte(8'hBA, 1'b1);
    for (int k = 0; k < 11; k++) send_byte(f2[87 - 8*k -: 8], 1'b1);
    idle_bits(2);
    check("frame2_header", 88'(frame_o[87:72]), 88'hBAFD);
    check("frame2_hold", frame_o, f2);

    // Framing error on 5th byte, then a full valid frame
    send_byte(8'hBA, 1'b1);
    send_byte(8'hFD, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b0);
    idle_bits(3);
    check("err_frame_unchanged", frame_o, f2);
    check("err_consumed", 88'(exp_errs), 88'd0);
    send_frame(f3);
    idle_bits(2);
    check("frame3_hold", frame_o, f3);

    // 3-cycle low glitch while idle
    @(negedge clk);
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_state_idle", 88'(u_dut.u_rx.r_state), 88'(ST_IDLE));
    check("glitch_byte_unchanged", 88'(byte_o), 88'h38);

    // Reset during bit 4 of the 7th frame byte
    for (int k = 0; k < 6; k++) send_byte(f4[87 - 8*k -: 8], 1'b1);
    b7 = f4[39:32];
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b7[i]);
    @(negedge clk);
    rx_i = b7[4];
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    hold_frame = '0;
    #1;
    check("async_rst_byte_o", 88'(byte_o), 88'h0);
    check("async_rst_frame_o", frame_o, 88'h0);
    check("async_rst_pulses", 88'({byte_valid_o, frame_valid_o, err_o}), 88'h0);
    check("async_rst_idx", 88'(u_dut.r_idx), 88'h0);
    @(negedge clk);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    check("post_rst_frame_hold", frame_o, hold_frame);
    send_frame(f5);
    idle_bits(2);
    check("frame5_hold", frame_o, f5);

    // Drain
    repeat (30) @(negedge clk);
    check("bytes_drained", 88'(exp_bytes.size()), 88'd0);
    check("frames_drained", 88'(exp_frames.size()), 88'd0);
    check("errs_drained", 88'(exp_errs), 88'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_frame_receiver
`default_nettype wire

// File: doc/uart_frame_receiver.md
UART_FRAME_RECEIVER -- requirements
Module: uart_frame_receiver

Interface
REQ-001 The block SHALL have parameter clkfreq, default 100000000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter baudrate, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port rx_i  input  1  meaning the asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port byte_o  output  8  meaning the last correctly received byte.
REQ-007 The block SHALL have port byte_valid_o  output  1  meaning a 1-cycle pulse when byte_o updates.
REQ-008 The block SHALL have port frame_o  output  88  meaning the last complete frame, in the same layout the transmitter consumes on din_i.
REQ-009 The block SHALL have port frame_valid_o  output  1  meaning a 1-cycle pulse when frame_o updates.
REQ-010 The block SHALL have port err_o  output  1  meaning a 1-cycle pulse on a framing error (stop bit sampled low).

Function
REQ-011 The block SHALL pass rx_i through a 2-flop synchronizer (both flops reset to 1) before any use; the result is rx_s.
REQ-012 Bit timing SHALL be BIT_LIM = clkfreq/baudrate cycles, using a timer ceil(log2(BIT_LIM)) bits wide.
REQ-013 The byte FSM SHALL have states IDLE, START, DATA, STOP, and SHALL enter IDLE at reset.
- IDLE: when rx_s == 0, go to START and clear the timer.
- START: after BIT_LIM/2 cycles, sample rx_s. If 0, go to DATA with the timer cleared. If 1 (glitch), return to IDLE with no output.
- DATA: every BIT_LIM cycles, sample rx_s into bit[n], n = 0..7 (LSB first). After bit 7, go to STOP.
- STOP: after BIT_LIM cycles, sample rx_s. If 1, load byte_o and pulse byte_valid_o. If 0, pulse err_o and do not change byte_o. Either way, go to IDLE in the same cycle, mid stop bit.
REQ-014 Back-to-back bytes, with a start edge arriving half a bit after the stop sample, SHALL be received without loss.
REQ-015 The frame assembler SHALL keep an index idx in 0..10, updated only on byte_valid_o or err_o.
REQ-016 The header SHALL be matched as follows:
- idx 0 accepts only 0xBA; any other byte keeps idx at 0.
- idx 1 accepts only 0xFD. 0xBA keeps idx at 1; any other byte sets idx to 0.
REQ-017 Accepted bytes SHALL be stored MSB-first: byte k is written to bits [87-8k : 80-8k].
REQ-018 On acceptance of byte 10, the block SHALL update frame_o and pulse frame_valid_o in the cycle after byte_valid_o, then set idx to 0.
REQ-019 Byte-to-frame latency SHALL be exactly 1 cycle.
REQ-020 frame_o SHALL hold its value until the next complete frame.
REQ-021 err_o SHALL set idx to 0 and discard the partial frame; frame_o SHALL remain unchanged.
REQ-022 byte_valid_o, frame_valid_o and err_o SHALL never be high for more than 1 consecutive cycle.
REQ-023 byte_valid_o and err_o SHALL be mutually exclusive.

Reset
REQ-024 Reset SHALL force the following values:
- FSM to IDLE; timer, bit count and idx to 0.
- synchronizer flops to 1.
- byte_o to 0x00 and frame_o to 88'h0.
- byte_valid_o, frame_valid_o and err_o to 0.
REQ-025 Reset asserted mid-byte or mid-frame SHALL abandon the byte or frame with no output pulse; reception SHALL restart at the next falling edge after release.

Structure
REQ-026 A shared package SHALL hold: the header constants HDR0 = 8'hBA and HDR1 = 8'hFD; FRAME_BYTES = 11; FRAME_W = 88; and the FSM state encoding (shared with the transmitter).
REQ-027 The byte FSM SHALL be the sub-module uart_rx_byte (clk, rst, rx_i, byte_o, byte_valid_o, err_o). uart_frame_receiver instantiates it and contains the assembler.

Verification (run with clkfreq = 1000000, baudrate = 100000, so BIT_LIM = 10)
REQ-028 Single byte 0x55, driven 8N1 -> byte_valid_o pulses once, byte_o = 0x55, err_o stays 0.
REQ-029 Frame BA FD 00 01 02 03 04 05 06 07 08, sent back-to-back -> one frame_valid_o pulse with frame_o = 88'hBAFD_0001_0203_0405_0607_08, 1 cycle after the 11th byte_valid_o.
REQ-030 Leading garbage 11 BA BA FD followed by 9 data bytes -> exactly one frame, with frame_o[87:72] = 16'hBAFD.
REQ-031 Stop bit forced low on the 5th byte of a frame, then a full valid frame -> err_o pulses once, frame_o is unchanged until the second frame completes, then matches it.
REQ-032 A rx_i low glitch of 3 cycles while idle -> no byte_valid_o and no err_o; the FSM returns to IDLE.
REQ-033 rst asserted during bit 4 of the 7th frame byte -> all outputs return to their reset values immediately (asynchronously); a subsequent full frame is received correctly.
